if_fetch_stage: RTL and testbench

- Pipelined instruction-fetch stage: owns the PC register and the instruction-memory request handshake, and drives the IF/ID pipeline register feeding the decode stage (yID-equivalent).
- Takes the interrupt/entry-point load (INT/entryPoint) and branch/jump redirects resolved downstream.
- Applies decode-stage stall and flush.
- Absorbs one in-flight memory response when the pipeline stalls.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/if_hold_buf.sv | 37 +++
 rtl/if_fetch_stage.sv | 153 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage state encoding, reset entry point and
// the opcode constants used by the control decode.
package cpu_pkg;

  typedef enum logic [2:0] {
    IF_IDLE,
    IF_REQ,
    IF_WAIT,
    IF_KILL,
    IF_HOLD
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0080;
  localparam logic [31:0] NOP_INS          = 32'h0000_0000;

  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry instruction/PC buffer that parks a memory response arriving
// while decode is stalled; clear (flush) wins over load and drain.
module if_hold_buf
  import cpu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic          clear,
  input  logic [31:0]   ins_d,
  input  logic [AW-1:0] pc_d,
  output logic          valid,
  output logic [31:0]   ins,
  output logic [AW-1:0] pc
);

  // NOTE: data registers are reset as well, so the buffer never presents X
  // to the IF/ID register even if a drain were ever mis-sequenced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ins   <= NOP_INS;
      pc    <= '0;
    end else if (clear || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      valid <= 1'b1;
      ins   <= ins_d;
      pc    <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake and IF/ID
// register. Optional counters fetch_cnt/kill_cnt under `IF_PERF_CNT_EN.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          int_req,
  input  logic [AW-1:0] entry_point,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_valid,
  input  logic [31:0]   imem_rdata,
  output logic          if_id_valid,
  output logic [31:0]   if_id_ins,
  output logic [AW-1:0] if_id_pc,
  output logic [AW-1:0] if_id_pcp4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_cnt,
  output logic [15:0]   kill_cnt
`endif
);

  if_state_e     state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_p4;
  logic          redir;
  logic [AW-1:0] redir_pc;
  logic          granted;
  logic          ifid_free;
  logic          take_new;
  logic          park;
  logic          take_hold;
  logic          drop;
  logic          hb_valid;
  logic [31:0]   hb_ins;
  logic [AW-1:0] hb_pc;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    redir    = 1'b0;
    redir_pc = pc_q;
    if (int_req) begin
      redir    = 1'b1;
      redir_pc = entry_point;
    end else if (redirect_valid) begin
      redir    = 1'b1;
      redir_pc = redirect_pc;
    end
  end

  assign pc_p4     = pc_q + AW'(4);
  assign granted   = imem_req && imem_gnt;
  assign ifid_free = !if_id_valid || !stall;
  assign take_new  = (state_q == IF_WAIT) && imem_valid && !redir && ifid_free;
  assign park      = (state_q == IF_WAIT) && imem_valid && !redir && !ifid_free;
  assign take_hold = (state_q == IF_HOLD) && !stall && !redir && hb_valid;
  assign drop      = imem_valid && ((state_q == IF_KILL) || ((state_q == IF_WAIT) && redir));

  // The request is raised one cycle after entering REQ so imem_addr is
  // always a registered copy of pc_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IF_IDLE;
      pc_q      <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      if (redir)                 pc_q <= redir_pc;
      else if (take_new || park) pc_q <= pc_p4;

      case (state_q)
        IF_IDLE: state_q <= IF_REQ;
        IF_REQ: begin
          if (granted) begin
            imem_req <= 1'b0;
            state_q  <= redir ? IF_KILL : IF_WAIT;
          end else if (redir) begin
            imem_req <= 1'b0;
          end else begin
            imem_req  <= 1'b1;
            imem_addr <= {pc_q[AW-1:2], 2'b00};
          end
        end
        IF_WAIT: begin
          if (redir)           state_q <= imem_valid ? IF_REQ : IF_KILL;
          else if (take_new)   state_q <= IF_REQ;
          else if (park)       state_q <= IF_HOLD;
        end
        IF_KILL: if (imem_valid) state_q <= IF_REQ;
        IF_HOLD: if (redir || !stall) state_q <= IF_REQ;
        default: state_q <= IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_ins   <= NOP_INS;
      if_id_pc    <= '0;
      if_id_pcp4  <= '0;
    end else if (redir) begin
      if_id_valid <= 1'b0;
    end else if (take_new) begin
      if_id_valid <= 1'b1;
      if_id_ins   <= imem_rdata;
      if_id_pc    <= pc_q;
      if_id_pcp4  <= pc_p4;
    end else if (take_hold) begin
      if_id_valid <= 1'b1;
      if_id_ins   <= hb_ins;
      if_id_pc    <= hb_pc;
      if_id_pcp4  <= hb_pc + AW'(4);
    end else if (!stall) begin
      if_id_valid <= 1'b0;
    end
  end

  if_hold_buf #(.AW(AW)) u_hold_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (park),
    .drain (take_hold),
    .clear (redir),
    .ins_d (imem_rdata),
    .pc_d  (pc_q),
    .valid (hb_valid),
    .ins   (hb_ins),
    .pc    (hb_pc)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (take_new || take_hold) fetch_cnt <= fetch_cnt + 32'd1;
      if (drop)                  kill_cnt  <= kill_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a one-outstanding memory responder;
// counter checks are compiled in when IF_PERF_CNT_EN is defined.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        int_req;
  logic [31:0] entry_point;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_ins;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pcp4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [15:0] kill_cnt;
`endif

  logic        gnt_en;
  int          resp_delay;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          n_cmp;
  int          n_err;

  if_fetch_stage dut (
`ifdef IF_PERF_CNT_EN
    .fetch_cnt      (fetch_cnt),
    .kill_cnt       (kill_cnt),
`endif
    .clk            (clk),
    .rst_n          (rst_n),
    .int_req        (int_req),
    .entry_point    (entry_point),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_ins      (if_id_ins),
    .if_id_pc       (if_id_pc),
    .if_id_pcp4     (if_id_pcp4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    if (a == 32'h84) return 32'h2009_0005;
    return 32'hA000_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
  endtask

  // Memory model: grant decided at negedge, response resp_delay cycles later.
  initial begin
    imem_gnt   = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    pend_cnt   = 0;
    pend_addr  = '0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = ins_of(pend_addr);
        end
      end
      imem_gnt = gnt_en;
      if (imem_req && imem_gnt) begin
        pend_addr = imem_addr;
        pend_cnt  = resp_delay;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; stall = 1'b0; int_req = 1'b0; entry_point = '0;
    redirect_valid = 1'b0; redirect_pc = '0; gnt_en = 1'b1; resp_delay = 1;

    // Reset values, then steady fetch stream.
    repeat (3) tick();
    check("rst_req",  imem_req,    32'h0);
    check("rst_addr", imem_addr,   32'h80);
    check("rst_vld",  if_id_valid, 32'h0);
    check("rst_ins",  if_id_ins,   32'h0);
    check("rst_pc",   if_id_pc,    32'h0);
    check("rst_pcp4", if_id_pcp4,  32'h0);
    rst_n = 1'b1;
    tick(); tick();
    check("first_req",  imem_req,  32'h1);
    check("first_addr", imem_addr, 32'h80);
    tick();
    check("req_drop", imem_req, 32'h0);
    tick();
    check("f0_vld",  if_id_valid, 32'h1);
    check("f0_pc",   if_id_pc,    32'h80);
    check("f0_pcp4", if_id_pcp4,  32'h84);
    check("f0_ins",  if_id_ins,   ins_of(32'h80));
    tick();
    check("bubble", if_id_valid, 32'h0);
    tick(); tick();
    check("f1_pc",  if_id_pc,  32'h84);
    check("f1_ins", if_id_ins, 32'h2009_0005);
    repeat (3) tick();
    check("f2_pc",   if_id_pc,   32'h88);
    check("f2_pcp4", if_id_pcp4, 32'h8C);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, 32'd3);
`endif

    // Stall while a response lands: parked in the hold buffer.
    do_reset();
    repeat (4) tick();
    check("st_pre_pc", if_id_pc, 32'h80);
    stall = 1'b1;
    repeat (3) tick();
    check("st_hold_req", imem_req,    32'h0);
    check("st_hold_pc",  if_id_pc,    32'h80);
    check("st_hold_vld", if_id_valid, 32'h1);
    tick();
    check("st_hold_req2", imem_req,  32'h0);
    check("st_hold_ins",  if_id_ins, ins_of(32'h80));
    stall = 1'b0;
    tick();
    check("st_out_ins",  if_id_ins,   32'h2009_0005);
    check("st_out_pc",   if_id_pc,    32'h84);
    check("st_out_pcp4", if_id_pcp4,  32'h88);
    check("st_out_vld",  if_id_valid, 32'h1);
    tick();
    check("st_next_req",  imem_req,  32'h1);
    check("st_next_addr", imem_addr, 32'h88);

    // Redirect while WAIT sees the response: word dropped.
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hA0;
    tick();
    redirect_valid = 1'b0;
    check("rd_vld", if_id_valid, 32'h0);
    check("rd_req", imem_req,    32'h0);
`ifdef IF_PERF_CNT_EN
    check("rd_kill_cnt", kill_cnt, 32'd1);
`endif
    tick();
    check("rd_req2", imem_req,  32'h1);
    check("rd_addr", imem_addr, 32'hA0);
    tick(); tick();
    check("rd_f_pc",  if_id_pc,    32'hA0);
    check("rd_f_ins", if_id_ins,   ins_of(32'hA0));
    check("rd_f_vld", if_id_valid, 32'h1);

    // Redirect before the response: KILL absorbs it; address is aligned.
    do_reset();
    resp_delay = 3;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hB3;
    tick();
    redirect_valid = 1'b0;
    check("kl_req0", imem_req, 32'h0);
    tick();
    check("kl_req1", imem_req,    32'h0);
    check("kl_vld",  if_id_valid, 32'h0);
    tick();
    check("kl_req2", imem_req,    32'h0);
    check("kl_vld2", if_id_valid, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("kl_kill_cnt", kill_cnt, 32'd1);
`endif
    tick();
    resp_delay = 1;
    check("kl_req3", imem_req,  32'h1);
    check("kl_addr", imem_addr, 32'hB0);
    tick(); tick();
    check("kl_f_ins", if_id_ins, ins_of(32'hB0));

    // int_req beats redirect and flushes despite stall.
    do_reset();
    repeat (4) tick();
    check("int_pre_vld", if_id_valid, 32'h1);
    stall = 1'b1; int_req = 1'b1; entry_point = 32'h80;
    redirect_valid = 1'b1; redirect_pc = 32'hC0;
    tick();
    stall = 1'b0; int_req = 1'b0; redirect_valid = 1'b0;
    check("int_flush", if_id_valid, 32'h0);
    tick();
    check("int_req",  imem_req,  32'h1);
    check("int_addr", imem_addr, 32'h80);

    // Grant withheld: request and address stay put.
    gnt_en = 1'b0;
    do_reset();
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ng_req%0d", i),  imem_req,  32'h1);
      check($sformatf("ng_addr%0d", i), imem_addr, 32'h80);
      if (i < 3) tick();
    end
    gnt_en = 1'b1;
    tick();
    check("ng_drop", imem_req, 32'h0);
    tick();
    check("ng_f_pc", if_id_pc, 32'h80);

    // Async reset in WAIT; the late response after release is ignored.
    do_reset();
    repeat (6) tick();
    rst_n = 1'b0; gnt_en = 1'b0;
    #1;
    check("ar_req",  imem_req,    32'h0);
    check("ar_addr", imem_addr,   32'h80);
    check("ar_pc",   if_id_pc,    32'h0);
    check("ar_vld",  if_id_valid, 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    check("ar_late_vld", if_id_valid, 32'h0);
    gnt_en = 1'b1;
    tick();
    check("ar_req2",  imem_req,  32'h1);
    check("ar_addr2", imem_addr, 32'h80);
    tick(); tick();
    check("ar_f_pc",  if_id_pc,  32'h80);
    check("ar_f_ins", if_id_ins, ins_of(32'h80));

    // PC wraps modulo 2^32.
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); tick();
    check("wr_pc",   if_id_pc,   32'hFFFF_FFFC);
    check("wr_pcp4", if_id_pcp4, 32'h0);
    tick();
    check("wr_next_addr", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
